// File: rtl/rns_pkg.sv
// Shared constants and state encoding for the {8,7,5,3} residue number system
// reverse converter.
package rns_pkg;

  // Moduli in mixed-radix order.
  localparam int unsigned M1 = 8;
  localparam int unsigned M2 = 7;
  localparam int unsigned M3 = 5;
  localparam int unsigned M4 = 3;

  // Dynamic range and the split point between positive and negative values.
  localparam int unsigned M_DYN = 840;
  localparam int unsigned HALF  = 420;

  // Mixed-radix weights: 8, 8*7, 8*7*5.
  localparam int unsigned W2 = 8;
  localparam int unsigned W3 = 56;
  localparam int unsigned W4 = 280;

  // Multiplicative inverses: INV_a_b = (a mod b)^-1 mod b.
  localparam int unsigned INV_8_7 = 1;
  localparam int unsigned INV_8_5 = 2;
  localparam int unsigned INV_7_5 = 3;
  localparam int unsigned INV_8_3 = 2;
  localparam int unsigned INV_7_3 = 1;
  localparam int unsigned INV_5_3 = 2;

  // One state per mixed-radix digit, then accumulate, then hand off.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_D2   = 3'd1,
    S_D3   = 3'd2,
    S_D4   = 3'd3,
    S_ACC  = 3'd4,
    S_OUT  = 3'd5
  } state_e;

endpackage

// File: rtl/rns_modsubmul.sv
// Combinational ((a - b) * k) mod m. Both operands are reduced mod m first, so
// the subtraction is done as (a + m - b) with no negative intermediate.
module rns_modsubmul #(
  parameter int unsigned M  = 7,
  parameter int unsigned K  = 1,
  parameter int unsigned AW = 3,
  parameter int unsigned BW = 3,
  parameter int unsigned YW = 3
) (
  input  logic [AW-1:0] a_i,
  input  logic [BW-1:0] b_i,
  output logic [YW-1:0] y_o
);

  logic [31:0] a_red;
  logic [31:0] b_red;
  logic [31:0] diff;
  logic [31:0] prod;

  assign a_red = 32'(a_i) % M;
  assign b_red = 32'(b_i) % M;
  assign diff  = a_red + M - b_red;
  assign prod  = diff * K;
  assign y_o   = YW'(prod % M);

endmodule

// File: rtl/rns2bin_mrc.sv
// Residue {8,7,5,3} to signed binary converter using iterative mixed-radix
// conversion, one digit per cycle, valid/ready on both sides.
module rns2bin_mrc
  import rns_pkg::*;
#(
  parameter int unsigned OUT_W   = 32,
  parameter bit          REG_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       r_1,
  input  logic [2:0]       r_2,
  input  logic [2:0]       r_3,
  input  logic [2:0]       r_4,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] n,
  output logic             err
);

  state_e state_q, state_d;

  logic [2:0] r2_q, r2_d;
  logic [2:0] r3_q, r3_d;
  logic [2:0] r4_q, r4_d;
  logic [2:0] a1_q, a1_d;
  logic [2:0] a2_q, a2_d;
  logic [2:0] a3_q, a3_d;
  logic [1:0] a4_q, a4_d;
  logic       bad_q, bad_d;
  logic       err_q, err_d;
  logic [OUT_W-1:0] n_q, n_d;

  logic [2:0] a2_w, t3_w, a3_w;
  logic [1:0] t4a_w, t4b_w, a4_w;
  logic       in_bad;
  logic [9:0] acc_w;
  logic signed [11:0] x_s;
  logic [OUT_W-1:0]   n_conv;

  // Digit 2: a2 = (r2 - a1) * inv(8) mod 7.
  rns_modsubmul #(.M(M2), .K(INV_8_7), .AW(3), .BW(3), .YW(3)) u_a2 (
    .a_i(r2_q), .b_i(a1_q), .y_o(a2_w)
  );

  // Digit 3, two chained steps evaluated in the same cycle.
  rns_modsubmul #(.M(M3), .K(INV_8_5), .AW(3), .BW(3), .YW(3)) u_t3 (
    .a_i(r3_q), .b_i(a1_q), .y_o(t3_w)
  );
  rns_modsubmul #(.M(M3), .K(INV_7_5), .AW(3), .BW(3), .YW(3)) u_a3 (
    .a_i(t3_w), .b_i(a2_q), .y_o(a3_w)
  );

  // Digit 4, three chained steps evaluated in the same cycle.
  rns_modsubmul #(.M(M4), .K(INV_8_3), .AW(3), .BW(3), .YW(2)) u_t4a (
    .a_i(r4_q), .b_i(a1_q), .y_o(t4a_w)
  );
  rns_modsubmul #(.M(M4), .K(INV_7_3), .AW(2), .BW(3), .YW(2)) u_t4b (
    .a_i(t4a_w), .b_i(a2_q), .y_o(t4b_w)
  );
  rns_modsubmul #(.M(M4), .K(INV_5_3), .AW(2), .BW(3), .YW(2)) u_a4 (
    .a_i(t4b_w), .b_i(a3_q), .y_o(a4_w)
  );

  // Residue 1 is 3 bits mod 8 and can never be out of range.
  assign in_bad = REG_ERR && ((r_2 >= 3'(M2)) || (r_3 >= 3'(M3)) || (r_4 >= 3'(M4)));

  // Mixed-radix accumulation, 0..839, folded into [-420, 419].
  assign acc_w  = 10'(a1_q) + 10'(a2_q) * 10'(W2) + 10'(a3_q) * 10'(W3)
                + 10'(a4_q) * 10'(W4);
  assign x_s    = (acc_w >= 10'(HALF)) ? $signed({2'b00, acc_w}) - $signed(12'(M_DYN))
                                       : $signed({2'b00, acc_w});
  assign n_conv = OUT_W'(x_s);

  // Next-state logic and per-state datapath updates.
  // NOTE: every target gets its hold value first so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    r4_d    = r4_q;
    a1_d    = a1_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    a4_d    = a4_q;
    bad_d   = bad_q;
    err_d   = err_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a1_d    = r_1;
          r2_d    = r_2;
          r3_d    = r_3;
          r4_d    = r_4;
          bad_d   = in_bad;
          state_d = S_D2;
        end
      end
      S_D2: begin
        a2_d    = a2_w;
        state_d = S_D3;
      end
      S_D3: begin
        a3_d    = a3_w;
        state_d = S_D4;
      end
      S_D4: begin
        a4_d    = a4_w;
        state_d = S_ACC;
      end
      S_ACC: begin
        n_d     = bad_q ? '0 : n_conv;
        err_d   = bad_q;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Captured residues, digits and result registers.
  // NOTE: this is a few flops rather than a memory, so all of it is cleared on
  // reset and an aborted conversion leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r2_q  <= '0;
      r3_q  <= '0;
      r4_q  <= '0;
      a1_q  <= '0;
      a2_q  <= '0;
      a3_q  <= '0;
      a4_q  <= '0;
      bad_q <= 1'b0;
      err_q <= 1'b0;
      n_q   <= '0;
    end else begin
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      r4_q  <= r4_d;
      a1_q  <= a1_d;
      a2_q  <= a2_d;
      a3_q  <= a3_d;
      a4_q  <= a4_d;
      bad_q <= bad_d;
      err_q <= err_d;
      n_q   <= n_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign n         = n_q;
  assign err       = REG_ERR ? err_q : 1'b0;

endmodule

// File: tb/tb_rns2bin_mrc.sv
// Directed bench for rns2bin_mrc: vector table, backpressure, mid-conversion
// reset and a full-range round trip against a residue encoder model.
module tb_rns2bin_mrc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  r_1, r_2, r_3, r_4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] n;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rns2bin_mrc #(.OUT_W(32), .REG_ERR(1'b1)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .r_1      (r_1),
    .r_2      (r_2),
    .r_3      (r_3),
    .r_4      (r_4),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .n        (n),
    .err      (err)
  );

  typedef struct {
    string       name;
    logic [2:0]  r1, r2, r3, r4;
    logic [31:0] exp_n;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", name, act, $signed(act),
               exp, $signed(exp));
    end
  endtask

  // Present a tuple from a falling edge; returns on the falling edge after
  // acceptance with the residue inputs scrambled.
  task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                      input logic [2:0] d);
    int k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    r_1 = a; r_2 = b; r_3 = c; r_4 = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    r_1 = 3'($urandom); r_2 = 3'($urandom); r_3 = 3'($urandom); r_4 = 3'($urandom);
  endtask

  // Count edges from acceptance until out_valid is seen, bounded.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send(v.r1, v.r2, v.r3, v.r4);
    wait_out(lat);
    check({v.name, "_latency"}, 32'(lat), 32'd4);
    check({v.name, "_n"}, n, v.exp_n);
    check({v.name, "_err"}, 32'(err), 32'(v.exp_err));
    take();
    check({v.name, "_in_ready_after"}, 32'(in_ready), 32'd1);
    check({v.name, "_out_valid_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;

    vecs[0]  = '{"zero",      3'd0, 3'd0, 3'd0, 3'd0, 32'd0,          1'b0};
    vecs[1]  = '{"max_pos",   3'd3, 3'd6, 3'd4, 3'd2, 32'd419,        1'b0};
    vecs[2]  = '{"min_neg",   3'd4, 3'd0, 3'd0, 3'd0, 32'hFFFFFE5C,   1'b0};
    vecs[3]  = '{"minus_one", 3'd7, 3'd6, 3'd4, 3'd2, 32'hFFFFFFFF,   1'b0};
    vecs[4]  = '{"bad_r2",    3'd0, 3'd7, 3'd0, 3'd0, 32'd0,          1'b1};
    vecs[5]  = '{"one",       3'd1, 3'd1, 3'd1, 3'd1, 32'd1,          1'b0};
    vecs[6]  = '{"two",       3'd2, 3'd2, 3'd2, 3'd2, 32'd2,          1'b0};
    vecs[7]  = '{"m280",      3'd0, 3'd0, 3'd0, 3'd2, -32'sd280,      1'b0};
    vecs[8]  = '{"m336",      3'd0, 3'd0, 3'd4, 3'd0, -32'sd336,      1'b0};
    vecs[9]  = '{"bad_r3",    3'd1, 3'd1, 3'd5, 3'd1, 32'd0,          1'b1};
    vecs[10] = '{"bad_r4",    3'd0, 3'd0, 3'd0, 3'd3, 32'd0,          1'b1};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    r_1 = '0; r_2 = '0; r_3 = '0; r_4 = '0;
    #12;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_n",         n,              32'd0);
    check("rst_err",       32'(err),       32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: result held, second tuple refused.
    send(3'd5, 3'd5, 3'd0, 3'd2);
    wait_out(lat);
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      r_1 = 3'd0; r_2 = 3'd0; r_3 = 3'd0; r_4 = 3'd0;
      check("bp_n_hold",        n,               32'd5);
      check("bp_out_valid",     32'(out_valid),  32'd1);
      check("bp_in_ready_low",  32'(in_ready),   32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    take();
    check("bp_in_ready_after",  32'(in_ready),  32'd1);
    check("bp_out_valid_after", 32'(out_valid), 32'd0);
    check("bp_n_after",         n,              32'd5);
    repeat (3) @(negedge clk);
    check("bp_no_second_accept", 32'(out_valid), 32'd0);
    check("bp_still_idle",       32'(in_ready),  32'd1);

    // Reset while the converter sits in D3.
    send(3'd1, 3'd1, 3'd1, 3'd1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    check("abort_n",         n,              32'd0);
    check("abort_err",       32'(err),       32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_result", 32'(out_valid), 32'd0);
    run_vec(vecs[1]);

    // Full-range round trip through a residue encoder model.
    for (int v = -420; v <= 419; v++) begin
      int e1, e2, e3, e4;
      e1 = ((v % 8) + 8) % 8;
      e2 = ((v % 7) + 7) % 7;
      e3 = ((v % 5) + 5) % 5;
      e4 = ((v % 3) + 3) % 3;
      send(3'(e1), 3'(e2), 3'(e3), 3'(e4));
      wait_out(lat);
      check("sweep_n",   n,        32'(v));
      check("sweep_err", 32'(err), 32'd0);
      take();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
